// File: rtl/uart_cmd_seq_if.sv
// uart_cmd_seq_if: byte-level handshake between uart_cmd_seq (master) and the uart FIFOs (slave).
interface uart_cmd_seq_if #(parameter int DBIT = 8);
    logic            uart_wr;
    logic [DBIT-1:0] uart_wdata;
    logic            uart_tx_full;
    logic            uart_rd;
    logic [DBIT-1:0] uart_rdata;
    logic            uart_rx_empty;
    logic            uart_err;
    modport master (output uart_wr, uart_wdata, uart_rd, input uart_tx_full, uart_rdata, uart_rx_empty, uart_err);
    modport slave  (input uart_wr, uart_wdata, uart_rd, output uart_tx_full, uart_rdata, uart_rx_empty, uart_err);
endinterface

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: sends a ROM command through the uart, then collects the reply until PROMPT or timeout.
// Optional UART_CMD_SEQ_STRIP_CR_EN: received CR/LF bytes are popped but not stored.
module uart_cmd_seq #(
    parameter int              DBIT     = 8,
    parameter int              CMD_AW   = 4,
    parameter int              RSP_AW   = 5,
    parameter int              TMO_BITS = 24,
    parameter logic [DBIT-1:0] PROMPT   = 8'h3E
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CMD_AW:0]     cmd_len,
    input  logic [TMO_BITS-1:0] tmo_limit,
    output logic [CMD_AW-1:0]   cmd_addr,
    input  logic [DBIT-1:0]     cmd_data,
    input  logic [RSP_AW-1:0]   rsp_raddr,
    output logic [DBIT-1:0]     rsp_rdata,
    output logic [RSP_AW:0]     rsp_len,
    output logic                busy,
    output logic                done,
    output logic                err_tmo,
    output logic                err_ovf,
    output logic                err_uart,
    uart_cmd_seq_if.master      u
);
    localparam int DEPTH = 2 ** RSP_AW;

    typedef enum logic [3:0] {
        IDLE, FETCH, TX_WAIT, TX_PULSE, TX_GAP, RX_WAIT, RX_POP, RX_GAP1, RX_GAP2, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CMD_AW:0]       len_q, len_d, idx_q, idx_d;
    logic [TMO_BITS-1:0]   tmo_q, tmo_d, timer_q, timer_d;
    logic [DBIT-1:0]       wdata_q, wdata_d, byte_q, byte_d;
    logic [RSP_AW:0]       rsp_len_q, rsp_len_d;
    logic                  err_tmo_q, err_tmo_d, err_ovf_q, err_ovf_d, err_uart_q, err_uart_d;
    logic                  we, keep, tmo_hit;
    logic [DBIT-1:0]       mem [DEPTH];

`ifdef UART_CMD_SEQ_STRIP_CR_EN
    assign keep = byte_q != DBIT'('h0D) && byte_q != DBIT'('h0A);
`else
    assign keep = 1'b1;
`endif

    // a zero limit times out on the first empty cycle
    assign tmo_hit = tmo_q == '0 || timer_q + TMO_BITS'(1) == tmo_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        wdata_d    = wdata_q;
        byte_d     = byte_q;
        rsp_len_d  = rsp_len_q;
        err_tmo_d  = err_tmo_q;
        err_ovf_d  = err_ovf_q;
        err_uart_d = err_uart_q | (state_q != IDLE && u.uart_err);
        we         = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                len_d      = cmd_len;
                tmo_d      = tmo_limit;
                idx_d      = '0;
                timer_d    = '0;
                rsp_len_d  = '0;
                err_tmo_d  = 1'b0;
                err_ovf_d  = 1'b0;
                err_uart_d = 1'b0;
                state_d    = cmd_len == '0 ? RX_WAIT : FETCH;
            end
            FETCH:    state_d = TX_WAIT;
            TX_WAIT: if (!u.uart_tx_full) begin
                wdata_d = cmd_data;
                state_d = TX_PULSE;
            end
            TX_PULSE: state_d = TX_GAP;
            TX_GAP: begin
                idx_d   = idx_q + (CMD_AW+1)'(1);
                timer_d = '0;
                state_d = idx_d == len_q ? RX_WAIT : FETCH;
            end
            RX_WAIT: if (!u.uart_rx_empty) begin
                byte_d  = u.uart_rdata;
                state_d = RX_POP;
            end else if (tmo_hit) begin
                err_tmo_d = 1'b1;
                state_d   = DONE;
            end else begin
                timer_d = timer_q + TMO_BITS'(1);
            end
            RX_POP:  state_d = RX_GAP1;
            RX_GAP1: state_d = RX_GAP2;
            RX_GAP2: if (byte_q == PROMPT) begin
                state_d = DONE;
            end else begin
                timer_d = '0;
                state_d = RX_WAIT;
                // rsp_len saturates at DEPTH, so its top bit marks a full buffer
                if (keep && rsp_len_q[RSP_AW]) err_ovf_d = 1'b1;
                else if (keep) begin
                    we        = 1'b1;
                    rsp_len_d = rsp_len_q + (RSP_AW+1)'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            wdata_q    <= '0;
            byte_q     <= '0;
            rsp_len_q  <= '0;
            err_tmo_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_uart_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            wdata_q    <= wdata_d;
            byte_q     <= byte_d;
            rsp_len_q  <= rsp_len_d;
            err_tmo_q  <= err_tmo_d;
            err_ovf_q  <= err_ovf_d;
            err_uart_q <= err_uart_d;
            if (we) mem[rsp_len_q[RSP_AW-1:0]] <= byte_q;
        end
    end

    assign cmd_addr     = idx_q[CMD_AW-1:0];
    assign rsp_rdata    = mem[rsp_raddr];
    assign rsp_len      = rsp_len_q;
    assign busy         = state_q != IDLE && state_q != DONE;
    assign done         = state_q == DONE;
    assign err_tmo      = err_tmo_q;
    assign err_ovf      = err_ovf_q;
    assign err_uart     = err_uart_q;
    assign u.uart_wr    = state_q == TX_PULSE;
    assign u.uart_rd    = state_q == RX_POP;
    assign u.uart_wdata = wdata_q;
endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: randomized transactions against a uart FIFO model and a byte-list reference model.
module tb_uart_cmd_seq;
    localparam int RSP_AW = 2;
    localparam int DEPTH  = 4;
`ifdef UART_CMD_SEQ_STRIP_CR_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [4:0]  cmd_len = '0;
    logic [23:0] tmo_limit = '0;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [1:0]  rsp_raddr = '0;
    logic [7:0]  rsp_rdata;
    logic [2:0]  rsp_len;
    logic        busy, done, err_tmo, err_ovf, err_uart;

    uart_cmd_seq_if #(.DBIT(8)) u();

    uart_cmd_seq #(.RSP_AW(RSP_AW)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_len(cmd_len), .tmo_limit(tmo_limit),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_raddr(rsp_raddr), .rsp_rdata(rsp_rdata),
        .rsp_len(rsp_len), .busy(busy), .done(done), .err_tmo(err_tmo), .err_ovf(err_ovf),
        .err_uart(err_uart), .u(u)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];
    logic [7:0] resp_arr [32];
    int         resp_n = 0;
    logic [7:0] tx_log [$], rx_q [$], pend_q [$];
    int         wr_cyc [$];
    int         txn = 0, txn_seen = 0, cyc = 0, st_cyc = 0, done_cyc = 0, done_cnt = 0;
    int         wr_full = 0, full_cnt = 0, gap_cnt = 0, burst2 = 0, max_gap = 3;
    bit         rnd_full = 1'b0;
    logic       wr_p = 1'b0, rd_p = 1'b0;
    int         n_cmp = 0, n_bad = 0;

    always @(posedge clk) cmd_data <= rom[cmd_addr];

    // uart model: edge-triggered FIFOs, tx_full bursts only right after a write
    always @(posedge clk) begin
        int nc;
        cyc  <= cyc + 1;
        wr_p <= u.uart_wr;
        rd_p <= u.uart_rd;
        nc = full_cnt > 0 ? full_cnt - 1 : 0;
        if (txn != txn_seen) begin
            txn_seen <= txn;
            tx_log.delete(); wr_cyc.delete(); rx_q.delete(); pend_q.delete();
            done_cnt <= 0;
            wr_full  <= 0;
            gap_cnt  <= max_gap;
            nc = 0;
            for (int i = 0; i < resp_n; i++) pend_q.push_back(resp_arr[i]);
        end else begin
            if (u.uart_wr && !wr_p) begin
                if (u.uart_tx_full) wr_full <= wr_full + 1;
                if (tx_log.size() == 1 && burst2 > 0) nc = burst2;
                else if (rnd_full && $urandom_range(0, 1) == 1) nc = $urandom_range(1, 12);
                tx_log.push_back(u.uart_wdata);
                wr_cyc.push_back(cyc);
            end
            if (u.uart_rd && !rd_p && rx_q.size() > 0) void'(rx_q.pop_front());
            if (gap_cnt > 0) gap_cnt <= gap_cnt - 1;
            else if (pend_q.size() > 0) begin
                rx_q.push_back(pend_q.pop_front());
                gap_cnt <= $urandom_range(0, max_gap);
            end
            if (start) st_cyc <= cyc;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
        full_cnt        <= nc;
        u.uart_tx_full  <= nc > 0;
        u.uart_rx_empty <= rx_q.size() == 0;
        u.uart_rdata    <= rx_q.size() > 0 ? rx_q[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag, input int len, input bit exp_eu);
        logic [7:0] eb [$];
        bit eovf = 1'b0, etmo = 1'b1;
        for (int i = 0; i < resp_n; i++) begin
            if (resp_arr[i] == 8'h3E) begin
                etmo = 1'b0;
                break;
            end
            if (STRIP && (resp_arr[i] == 8'h0D || resp_arr[i] == 8'h0A)) continue;
            if (eb.size() < DEPTH) eb.push_back(resp_arr[i]);
            else eovf = 1'b1;
        end
        chk({tag, "_ntx"}, tx_log.size(), len);
        for (int i = 0; i < len && i < tx_log.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), tx_log[i], rom[i]);
        chk({tag, "_wr_full"}, wr_full, 0);
        chk({tag, "_rsp_len"}, rsp_len, eb.size());
        chk({tag, "_err_tmo"}, err_tmo, etmo);
        chk({tag, "_err_ovf"}, err_ovf, eovf);
        chk({tag, "_err_uart"}, err_uart, exp_eu);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ndone"}, done_cnt, 1);
        for (int i = 0; i < eb.size(); i++) begin
            rsp_raddr = 2'(i);
            #1;
            chk($sformatf("%s_rsp%0d", tag, i), rsp_rdata, eb[i]);
        end
    endtask

    task automatic run_txn(input string tag, input int len, input int tmo, input int err_at, input bit extra_start);
        bit pulsed = 1'b0;
        txn++;
        @(negedge clk);
        @(negedge clk);
        cmd_len   = 5'(len);
        tmo_limit = 24'(tmo);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (extra_start) begin
            @(negedge clk);
            chk({tag, "_busy_mid"}, busy, 1);
            start   = 1'b1;
            cmd_len = 5'd1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            u.uart_err = i == err_at;
            if (i == err_at) pulsed = 1'b1;
            @(negedge clk);
        end
        u.uart_err = 1'b0;
        chk({tag, "_done_seen"}, done_cnt > 0, 1);
        @(negedge clk);
        @(negedge clk);
        check_results(tag, len, pulsed);
    endtask

    task automatic set_resp(input string s);
        resp_n = s.len();
        for (int i = 0; i < s.len(); i++) resp_arr[i] = s[i];
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        u.uart_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", u.uart_wr, 0);
        chk("rst_rd", u.uart_rd, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_wdata", u.uart_wdata, 0);
        chk("rst_len", rsp_len, 0);
        chk("rst_errs", {err_tmo, err_ovf, err_uart}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 1'b1;

        // ATZ\r with a start attempted while busy
        rom[0] = 8'h41; rom[1] = 8'h54; rom[2] = 8'h5A; rom[3] = 8'h0D;
        set_resp("OK\r>");
        run_txn("t1", 4, 200, -1, 1'b1);

        // 50-cycle tx_full stall after the second byte
        for (int i = 0; i < 6; i++) rom[i] = 8'(8'h60 + i);
        set_resp("ab>");
        burst2 = 50;
        run_txn("t2", 6, 200, -1, 1'b0);
        chk("t2_stall", (wr_cyc.size() > 2) && (wr_cyc[2] - wr_cyc[1] >= 50), 1);
        burst2 = 0;

        // silent line: RX_WAIT begins on the start edge, done is sampled 101 edges later
        resp_n = 0;
        run_txn("t3", 0, 100, -1, 1'b0);
        chk("t3_lat", done_cyc - st_cyc, 101);

        // six data bytes overflow a four-byte buffer
        set_resp("123456>");
        run_txn("t4", 1, 200, -1, 1'b0);

        // reset while the second of four bytes is in flight
        for (int i = 0; i < 4; i++) rom[i] = 8'(8'hA0 + i);
        resp_n  = 0;
        txn++;
        @(negedge clk);
        @(negedge clk);
        cmd_len   = 5'd4;
        tmo_limit = 24'd200;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && tx_log.size() < 1; i++) @(negedge clk);
        chk("t5_first_wr", tx_log.size(), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_wr", u.uart_wr, 0);
        chk("t5_rd", u.uart_rd, 0);
        chk("t5_addr", cmd_addr, 0);
        repeat (3) @(negedge clk);
        chk("t5_ndone", done_cnt, 0);
        reset = 1'b1;
        set_resp("Z>");
        run_txn("t5b", 4, 200, -1, 1'b0);

        // uart_err pulse while waiting for a slow reply
        max_gap = 20;
        set_resp("hi>");
        run_txn("t6", 0, 200, 3, 1'b0);

        rnd_full = 1'b1;
        for (int t = 0; t < 24; t++) begin
            int len, n;
            len = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 8'h0D : 8'h0A) : 8'($urandom_range(0, 255));
                resp_arr[i] = b == 8'h3E ? 8'h3F : b;
            end
            resp_arr[n] = 8'h3E;
            resp_n  = n + 1;
            max_gap = $urandom_range(0, 8);
            run_txn($sformatf("r%0d", t), len, 200, $urandom_range(0, 1) ? int'($urandom_range(0, 40)) : -1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
